// File: rtl/nicnac16_pkg.sv
// Shared definitions for the NICNAC16 core: field widths, opcode map and
// the fetch-stage state encoding.
package nicnac16_pkg;

  localparam int ADDR_WIDTH   = 8;
  localparam int DATA_WIDTH   = 16;
  localparam int OPCODE_WIDTH = 4;

  typedef logic [OPCODE_WIDTH-1:0] opcode_t;

  // Control opcodes resolved inside the fetch stage.
  localparam opcode_t OP_HALT = 4'h0;
  localparam opcode_t OP_JMP  = 4'h1;

  // Remaining opcodes are executed downstream; fetch forwards them untouched.
  localparam opcode_t OP_LDI  = 4'h2;
  localparam opcode_t OP_LD   = 4'h3;
  localparam opcode_t OP_ADD  = 4'h4;
  localparam opcode_t OP_SUB  = 4'h5;
  localparam opcode_t OP_AND  = 4'h6;
  localparam opcode_t OP_OR   = 4'h7;
  localparam opcode_t OP_XOR  = 4'h8;
  localparam opcode_t OP_ST   = 4'h9;
  localparam opcode_t OP_BEQ  = 4'hA;
  localparam opcode_t OP_BNE  = 4'hB;
  localparam opcode_t OP_SHL  = 4'hC;
  localparam opcode_t OP_SHR  = 4'hD;
  localparam opcode_t OP_IN   = 4'hE;
  localparam opcode_t OP_OUT  = 4'hF;

  // Fetch stage state: actively fetching, or stopped on a HALT opcode.
  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with a load port (redirect / jump target) that
// has priority over the sequential increment. Arithmetic wraps modulo
// 2^ADDR_WIDTH.
module pc_reg #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] load_pc,
  output logic [ADDR_WIDTH-1:0] pc
);

  // PC update: reset, then load, then increment, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// NICNAC16 instruction fetch stage. Drives the combinational ROM from the
// PC, resolves JMP and HALT locally, and hands every other word to execute
// through a registered valid/ready instruction slot. A redirect from
// execute flushes the slot and reloads the PC.
module fetch_unit
  import nicnac16_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = nicnac16_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = nicnac16_pkg::DATA_WIDTH,
  parameter int                    OPCODE_WIDTH = nicnac16_pkg::OPCODE_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] VALUE,
  output logic [DATA_WIDTH-1:0] INSTR,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  input  logic                  REDIRECT,
  input  logic [ADDR_WIDTH-1:0] REDIRECT_PC,
  output logic                  HALTED
);

  fetch_state_t            state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [DATA_WIDTH-1:0]   instr_word;
  logic                    instr_pending;
  logic                    halted_flag;

  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    is_jmp;
  logic                    is_halt;
  logic                    slot_free;
  logic                    pc_load;
  logic                    pc_inc;
  logic [ADDR_WIDTH-1:0]   pc_load_value;

  assign opcode    = VALUE[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign is_jmp    = (opcode == OPCODE_WIDTH'(OP_JMP));
  assign is_halt   = (opcode == OPCODE_WIDTH'(OP_HALT));
  // The slot can take a new word when it is empty or being drained now.
  assign slot_free = !instr_pending || INSTR_READY;

  // ADDRESS comes straight from the PC register, never from an input.
  assign ADDRESS     = pc;
  assign INSTR       = instr_word;
  assign INSTR_VALID = instr_pending;
  assign HALTED      = halted_flag;

  // Next-PC selection: redirect beats everything, then JMP target, then +1.
  always_comb begin
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
    pc_load_value = REDIRECT_PC;
    case (state)
      FETCH: begin
        if (REDIRECT) begin
          pc_load       = 1'b1;
          pc_load_value = REDIRECT_PC;
        end else if (!slot_free) begin
          pc_load = 1'b0;
          pc_inc  = 1'b0;
        end else if (is_jmp) begin
          pc_load       = 1'b1;
          pc_load_value = VALUE[ADDR_WIDTH-1:0];
        end else if (is_halt) begin
          pc_load = 1'b0;
          pc_inc  = 1'b0;
        end else begin
          pc_inc = 1'b1;
        end
      end
      HALT: begin
        if (REDIRECT) begin
          pc_load       = 1'b1;
          pc_load_value = REDIRECT_PC;
        end else begin
          pc_load = 1'b0;
          pc_inc  = 1'b0;
        end
      end
      default: begin
        pc_load = 1'b0;
        pc_inc  = 1'b0;
      end
    endcase
  end

  pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk     (CLK),
    .reset   (RESET),
    .load    (pc_load),
    .inc     (pc_inc),
    .load_pc (pc_load_value),
    .pc      (pc)
  );

  // Fetch FSM with registered instruction slot and HALTED flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= FETCH;
      instr_word    <= {DATA_WIDTH{1'b0}};
      instr_pending <= 1'b0;
      halted_flag   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (REDIRECT) begin
            // Flush wins over a simultaneous handshake.
            instr_pending <= 1'b0;
          end else if (!slot_free) begin
            instr_pending <= instr_pending;
            instr_word    <= instr_word;
          end else if (is_jmp) begin
            // Jumps are consumed here: a one-cycle bubble, nothing issued.
            if (INSTR_READY) begin
              instr_pending <= 1'b0;
            end
          end else if (is_halt) begin
            if (INSTR_READY) begin
              instr_pending <= 1'b0;
            end
            state       <= HALT;
            halted_flag <= 1'b1;
          end else begin
            instr_word    <= VALUE;
            instr_pending <= 1'b1;
          end
        end
        HALT: begin
          if (REDIRECT) begin
            instr_pending <= 1'b0;
            halted_flag   <= 1'b0;
            state         <= FETCH;
          end else if (INSTR_READY) begin
            instr_pending <= 1'b0;
          end else begin
            instr_pending <= instr_pending;
          end
        end
        default: begin
          state         <= FETCH;
          instr_pending <= 1'b0;
          halted_flag   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural model of the fetch rules
// produces per-cycle expected outputs and the stream of issued instructions;
// a negedge monitor compares them against the DUT.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  address;
  logic [15:0] value;
  logic [15:0] instr;
  logic        instr_valid;
  logic        halted;

  logic [15:0] rom [256];

  always #5 clk = ~clk;

  assign value = rom[address];

  fetch_unit dut (
    .CLK         (clk),
    .RESET       (reset),
    .ADDRESS     (address),
    .VALUE       (value),
    .INSTR       (instr),
    .INSTR_VALID (instr_valid),
    .INSTR_READY (instr_ready),
    .REDIRECT    (redirect),
    .REDIRECT_PC (redirect_pc),
    .HALTED      (halted)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic        valid;
    logic [15:0] instr;
    logic        halted;
  } snap_t;

  snap_t       snaps[$];
  logic [15:0] issued[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state
  logic [7:0]  m_pc;
  bit          m_valid;
  bit          m_halted;
  bit          started = 1'b0;
  logic [15:0] m_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event at %0t", name, $time);
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_edge();
    logic [15:0] w;
    int          op;
    if (reset) begin
      m_pc = 8'd0; m_valid = 1'b0; m_instr = 16'h0000; m_halted = 1'b0;
      issued.delete();
      started = 1'b1;
    end else if (started) begin
      if (m_halted) begin
        if (redirect) begin
          if (m_valid) void'(issued.pop_back());
          m_pc = redirect_pc; m_valid = 1'b0; m_halted = 1'b0;
        end else if (instr_ready) begin
          m_valid = 1'b0;
        end
      end else if (redirect) begin
        if (m_valid) void'(issued.pop_back());
        m_pc = redirect_pc; m_valid = 1'b0;
      end else if (m_valid && !instr_ready) begin
        // blocked: everything holds
      end else begin
        w  = rom[m_pc];
        op = int'(w[15:12]);
        if (op == 1) begin
          m_pc = w[7:0]; m_valid = 1'b0;
        end else if (op == 0) begin
          m_valid = 1'b0; m_halted = 1'b1;
        end else begin
          m_instr = w; m_valid = 1'b1; m_pc = m_pc + 8'd1;
          issued.push_back(w);
        end
      end
    end
  endtask

  // One clock: record expected outputs for this cycle, step the model.
  task automatic step();
    if (started) snaps.push_back('{pc: m_pc, valid: m_valid, instr: m_instr, halted: m_halted});
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      reset = 1'b0; redirect = 1'b0; instr_ready = rdy;
      step();
    end
  endtask

  task automatic do_redirect(input logic [7:0] target);
    reset = 1'b0; redirect = 1'b1; redirect_pc = target; instr_ready = 1'b1;
    step();
    redirect = 1'b0;
  endtask

  task automatic run_until_valid(input logic [15:0] w, input int bound);
    int k = 0;
    while (!(m_valid && m_instr == w) && k < bound) begin
      run(1, 1'b1);
      k++;
    end
    if (!(m_valid && m_instr == w)) fail_now("wait_instr");
  endtask

  task automatic run_until_halted(input int bound);
    int k = 0;
    while (!m_halted && k < bound) begin
      run(1, 1'b1);
      k++;
    end
    if (!m_halted) fail_now("wait_halt");
  endtask

  // Monitor: compare the DUT against the expected snapshot and issue stream.
  always @(negedge clk) begin
    snap_t s;
    if (snaps.size() > 0) begin
      s = snaps.pop_front();
      check("address", 32'(address), 32'(s.pc));
      check("instr_valid", 32'(instr_valid), 32'(s.valid));
      check("instr", 32'(instr), 32'(s.instr));
      check("halted", 32'(halted), 32'(s.halted));
      if (instr_valid && instr_ready && !redirect && !reset) begin
        if (issued.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept: got instr %0h expected no accepted instruction at %0t", instr, $time);
        end else begin
          check("accepted_instr", 32'(instr), 32'(issued.pop_front()));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h2000 | 16'(i);
    rom[0] = 16'h1003; rom[3] = 16'h4001; rom[4] = 16'h5200;
    rom[5] = 16'h1003; rom[6] = 16'h0000;
    reset = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'd0;
    step();
    step();

    // Jump loop 0,3,4,5,3,4,...
    run(12, 1'b1);

    // Backpressure on 4001
    run_until_valid(16'h4001, 20);
    run(3, 1'b0);
    run(4, 1'b1);

    // Sequential HALT at address 6, then redirect to 3
    rom[5] = 16'h6000;
    run_until_halted(30);
    run(3, 1'b1);
    run(2, 1'b0);
    do_redirect(8'd3);
    run(4, 1'b1);

    // Redirect colliding with a handshake
    do_redirect(8'd3);
    run_until_valid(16'h4001, 10);
    do_redirect(8'h10);
    run(3, 1'b1);

    // PC wrap 255 -> 0
    rom[255] = 16'h7ABC; rom[0] = 16'h8DEF; rom[1] = 16'h0000;
    do_redirect(8'hFF);
    run(6, 1'b1);

    // Reset while halted
    reset = 1'b1; step();
    run(3, 1'b1);

    // Reset while an instruction is pending and stalled
    do_redirect(8'd3);
    run_until_valid(16'h4001, 10);
    reset = 1'b1; instr_ready = 1'b0; step();
    run(3, 1'b1);

    // Randomized program and control traffic
    for (int i = 0; i < 256; i++) begin
      int r;
      logic [3:0] op;
      r = $urandom_range(0, 7);
      op = (r == 0) ? 4'h0 : (r == 1) ? 4'h1 : 4'($urandom_range(2, 15));
      rom[i] = {op, 12'($urandom)};
    end
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 199) == 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = 8'($urandom_range(0, 255));
      instr_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    reset = 1'b0; redirect = 1'b0;

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the NICNAC16 core.
- Owns the program counter and drives the ROM ADDRESS. The ROM is combinational, so VALUE is valid in the same cycle.
- Latches the returned 16-bit word into an instruction register and hands it to the execute stage over a valid/ready handshake.
- Resolves unconditional jumps and HALT locally. Accepts a redirect from execute.

Parameters:
- ADDR_WIDTH, 8, PC and ROM address width.
- DATA_WIDTH, 16, instruction word width.
- OPCODE_WIDTH, 4, opcode field width, taken from the top bits of the word.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- ADDRESS  output  ADDR_WIDTH  ROM address; always equals PC.
- VALUE  input  DATA_WIDTH  ROM read data for ADDRESS, same cycle.
- INSTR  output  DATA_WIDTH  instruction register contents.
- INSTR_VALID  output  1  INSTR holds an instruction not yet accepted.
- INSTR_READY  input  1  execute stage accepts INSTR this cycle.
- REDIRECT  input  1  execute requests a PC change.
- REDIRECT_PC  input  ADDR_WIDTH  target for REDIRECT.
- HALTED  output  1  fetch stopped on a HALT opcode.

Behaviour:
- Reset: when RESET=1 at a clock edge:
  - PC=RESET_PC, INSTR=0, INSTR_VALID=0, HALTED=0, state=FETCH.
  - Reset overrides everything, including mid-handshake or HALT.
- Opcode is VALUE[DATA_WIDTH-1 -: OPCODE_WIDTH]. OP_HALT=4'b0000, OP_JMP=4'b0001. All other opcodes are issued downstream unchanged.
- Slot free: slot_free = !INSTR_VALID || INSTR_READY.
- State FETCH, per edge, priority order:
  - REDIRECT=1: PC<=REDIRECT_PC, INSTR_VALID<=0. Any pending instruction is flushed, even if INSTR_READY=1 in the same cycle; the handshake counts as not completed.
  - slot_free=0: hold PC, INSTR and INSTR_VALID.
  - Opcode OP_JMP: PC<=VALUE[ADDR_WIDTH-1:0]. Nothing is issued; INSTR_VALID<=0 if INSTR_READY, else held. One-cycle bubble.
  - Opcode OP_HALT: PC held, INSTR_VALID<=0 if INSTR_READY, state<=HALT, HALTED<=1.
  - Otherwise: INSTR<=VALUE, INSTR_VALID<=1, PC<=PC+1.
- State HALT:
  - HALTED=1; no fetch.
  - A pending INSTR_VALID still drains via INSTR_READY.
  - REDIRECT=1: PC<=REDIRECT_PC, INSTR_VALID<=0, HALTED<=0, state<=FETCH.
- PC arithmetic is modulo 2^ADDR_WIDTH: 255+1 wraps to 0, no flag.
- Throughput and latency:
  - One instruction per cycle when INSTR_READY is held high.
  - Latency from PC update to INSTR_VALID is 1 cycle.
- INSTR and INSTR_VALID are registered outputs. INSTR is stable while INSTR_VALID && !INSTR_READY.
- ADDRESS is combinational from the PC register only; there is no path from inputs to ADDRESS.
- Jump to self (JMP at address n targeting n): legal. Loops with no issue until REDIRECT or RESET.

Decomposition:
- Shared package nicnac16_pkg:
  - OPCODE_WIDTH, ADDR_WIDTH, DATA_WIDTH.
  - OP_HALT, OP_JMP and remaining opcode constants.
  - Fetch state enumeration {FETCH, HALT}.
- No sub-module is required. The PC register with increment/load mux may be split out as pc_reg if execute needs the same structure.

Test Plan:
- Reset, then ROM image [0]=16'h1003, [3]=16'h4001, [4]=16'h5200, [5]=16'h1003, INSTR_READY=1:
  - ADDRESS sequence 0,3,4,5,3,4,…
  - INSTR issues 16'h4001, 16'h5200 repeatedly; a JMP is never issued.
- Backpressure: INSTR_READY=0 for 3 cycles while INSTR=16'h4001 is valid:
  - INSTR and ADDRESS=4 hold.
  - On READY=1, the next cycle shows INSTR=16'h5200.
- HALT: word at address 6 = 16'h0000 reached sequentially:
  - HALTED=1 and ADDRESS stays 6.
  - Then REDIRECT=1, REDIRECT_PC=3: HALTED=0 and fetch resumes at 3.
- Redirect collision: REDIRECT=1 with INSTR_VALID=1 and INSTR_READY=1 simultaneously:
  - INSTR_VALID=0 next cycle; PC=REDIRECT_PC.
  - The flushed instruction is not counted as accepted.
- Wrap: REDIRECT_PC=8'hFF with non-control words at 255 and 0:
  - ADDRESS goes 255 then 0; both words issued in order.
- Mid-operation reset: RESET=1 while in HALT with INSTR_VALID=1:
  - Next cycle PC=0, INSTR_VALID=0, HALTED=0, INSTR=0.
